// File: rtl/qsched_pkg.sv
// qsched_pkg: shared state encoding, parameter defaults and index-width helper
// for quantum_scheduler and its round-robin picker.
package qsched_pkg;

  localparam int unsigned NPROC_DEF = 4;
  localparam int unsigned QW_DEF    = 16;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    SAVE,
    SELECT,
    LOAD
  } state_e;

  // Width of a slot index; never below 1 so ports stay legal for tiny configs
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/quantum_scheduler_rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first set bit of
// mask found at start, start+1, ... (modulo NPROC).
module rr_pick
  import qsched_pkg::*;
#(
  parameter int unsigned NPROC = NPROC_DEF
) (
  input  logic [NPROC-1:0]        mask,
  input  logic [idx_w(NPROC)-1:0] start,
  output logic [idx_w(NPROC)-1:0] grant,
  output logic                    any_valid
);

  localparam int unsigned IW = idx_w(NPROC);

  // Index arithmetic wraps naturally because NPROC is a power of two
  always_comb begin
    grant     = start;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NPROC; i++) begin
      if (!any_valid && mask[start + IW'(i)]) begin
        grant     = start + IW'(i);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/quantum_scheduler.sv
// quantum_scheduler: time-slice preemptive scheduler for NPROC process slots.
// Counts retired-instruction ticks, stalls fetch via switch_req/switch_ack,
// saves the running PC and loads the next valid slot's PC.
// Optional feature: define QSCHED_OS_RETURN_EN to reserve slot 0 for the OS
// (every switch away from a user slot returns to slot 0; from slot 0 the
// round-robin continues over the user slots after the last user run).
module quantum_scheduler
  import qsched_pkg::*;
#(
  parameter int unsigned NPROC = NPROC_DEF,
  parameter int unsigned QW    = QW_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    tick,
  input  logic [QW-1:0]           quantum,
  input  logic [31:0]             cur_pc,
  input  logic                    proc_create,
  input  logic [idx_w(NPROC)-1:0] create_id,
  input  logic [31:0]             create_pc,
  input  logic                    proc_exit,
  output logic                    switch_req,
  input  logic                    switch_ack,
  output logic                    load_pc,
  output logic [31:0]             new_pc,
  output logic [idx_w(NPROC)-1:0] cur_proc,
  output logic                    idle
);

  localparam int unsigned IW = idx_w(NPROC);

  state_e           state_q, state_d;
  logic [QW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    cur_proc_q, cur_proc_d;
  logic [31:0]      new_pc_q, new_pc_d;
  logic             switch_req_q, switch_req_d;
  logic             exit_q, exit_d;
  logic [NPROC-1:0] valid_q, valid_d;
  logic [31:0]      saved_pc_q [NPROC];
  logic [31:0]      saved_pc_d [NPROC];
`ifdef QSCHED_OS_RETURN_EN
  logic [IW-1:0]    last_user_q, last_user_d;
`endif

  logic             create_ok;
  logic [NPROC-1:0] valid_cr;
  logic [NPROC-1:0] cur_oh;
  logic             others;
  logic [QW-1:0]    cnt_inc;
  logic             expire;
  logic [NPROC-1:0] rr_mask;
  logic [IW-1:0]    rr_start;
  logic [IW-1:0]    rr_grant;
  logic             rr_any;
  logic [IW-1:0]    sel_idx;
  logic             sel_any;
  logic [31:0]      sel_pc;

  // Creation admission, saturating count, expiry and search inputs.
  // valid_cr includes a same-cycle creation so SELECT and the expiry check see it.
  always_comb begin
    create_ok = proc_create && !(state_q == RUN && create_id == cur_proc_q);
    valid_cr  = valid_q;
    if (create_ok) valid_cr[create_id] = 1'b1;
    cur_oh             = '0;
    cur_oh[cur_proc_q] = 1'b1;
    others  = |(valid_cr & ~cur_oh);
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    expire  = tick && enable && (quantum != '0) && (cnt_inc == quantum);
    rr_mask = valid_cr;
`ifdef QSCHED_OS_RETURN_EN
    rr_mask[0] = 1'b0;
    rr_start   = last_user_q + 1'b1;
`else
    rr_start   = cur_proc_q + 1'b1;
`endif
  end

  rr_pick #(.NPROC(NPROC)) u_rr_pick (
    .mask      (rr_mask),
    .start     (rr_start),
    .grant     (rr_grant),
    .any_valid (rr_any)
  );

  // Successor slot and its PC (a same-cycle creation supplies the PC directly)
  always_comb begin
`ifdef QSCHED_OS_RETURN_EN
    if (cur_proc_q != '0 && valid_cr[0]) begin
      sel_idx = '0;
      sel_any = 1'b1;
    end else begin
      sel_idx = rr_grant;
      sel_any = rr_any;
    end
`else
    sel_idx = rr_grant;
    sel_any = rr_any;
`endif
    sel_pc = (create_ok && create_id == sel_idx) ? create_pc : saved_pc_q[sel_idx];
  end

  // Next-state, slot table and handshake control
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_proc_d   = cur_proc_q;
    new_pc_d     = new_pc_q;
    switch_req_d = switch_req_q;
    exit_d       = exit_q;
    valid_d      = valid_cr;
    saved_pc_d   = saved_pc_q;
`ifdef QSCHED_OS_RETURN_EN
    last_user_d  = last_user_q;
`endif
    if (create_ok) saved_pc_d[create_id] = create_pc;

    case (state_q)
      IDLE: begin
        if (proc_create) begin
          state_d    = LOAD;
          cur_proc_d = create_id;
          new_pc_d   = create_pc;
`ifdef QSCHED_OS_RETURN_EN
          if (create_id != '0) last_user_d = create_id;
`endif
        end
      end
      RUN: begin
        if (proc_exit) begin
          valid_d[cur_proc_q] = 1'b0;
          exit_d              = 1'b1;
          switch_req_d        = 1'b1;
          state_d             = DRAIN;
        end else if (tick) begin
          if (expire) begin
            if (others) begin
              exit_d       = 1'b0;
              switch_req_d = 1'b1;
              state_d      = DRAIN;
            end else begin
              cnt_d = '0;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      DRAIN: begin
        if (switch_ack) state_d = exit_q ? SELECT : SAVE;
      end
      SAVE: begin
        saved_pc_d[cur_proc_q] = cur_pc;
        state_d                = SELECT;
      end
      SELECT: begin
        if (sel_any) begin
          cur_proc_d = sel_idx;
          new_pc_d   = sel_pc;
          state_d    = LOAD;
`ifdef QSCHED_OS_RETURN_EN
          if (sel_idx != '0) last_user_d = sel_idx;
`endif
        end else begin
          switch_req_d = 1'b0;
          state_d      = IDLE;
        end
      end
      LOAD: begin
        switch_req_d = 1'b0;
        cnt_d        = '0;
        state_d      = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_proc_q   <= '0;
      new_pc_q     <= '0;
      switch_req_q <= 1'b0;
      exit_q       <= 1'b0;
      valid_q      <= '0;
      for (int unsigned i = 0; i < NPROC; i++) saved_pc_q[i] <= '0;
`ifdef QSCHED_OS_RETURN_EN
      last_user_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_proc_q   <= cur_proc_d;
      new_pc_q     <= new_pc_d;
      switch_req_q <= switch_req_d;
      exit_q       <= exit_d;
      valid_q      <= valid_d;
      saved_pc_q   <= saved_pc_d;
`ifdef QSCHED_OS_RETURN_EN
      last_user_q  <= last_user_d;
`endif
    end
  end

  assign switch_req = switch_req_q;
  assign load_pc    = (state_q == LOAD);
  assign new_pc     = new_pc_q;
  assign cur_proc   = cur_proc_q;
  assign idle       = (state_q == IDLE);

endmodule

// File: doc/quantum_scheduler.md
QUANTUM_SCHEDULER -- requirements
Module: quantum_scheduler

Interface
REQ-001 SHALL have parameter NPROC, default 4, giving the number of process slots (power of two, 2..8).
REQ-002 SHALL have parameter QW, default 16, giving the quantum counter width in bits.
REQ-003 SHALL have port clock, input, 1, the single clock for all state, the same gated CPU clock that drives the PC.
REQ-004 SHALL have port reset, input, 1, an asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1, driven by the control unit's usaQuantum; when low, no preemption occurs.
REQ-006 SHALL have port tick, input, 1, asserted for one cycle per retired instruction.
REQ-007 SHALL have port quantum, input, QW, the number of ticks allowed per time slice.
REQ-008 SHALL have port cur_pc, input, 32, the PC of the running process.
REQ-009 SHALL have ports proc_create (input, 1), create_id (input, log2 NPROC) and create_pc (input, 32), used to register a process.
REQ-010 SHALL have port proc_exit, input, 1, the current process has finished.
REQ-011 SHALL have ports switch_req (output, 1) and switch_ack (input, 1), the fetch-stall handshake with the CPU.
REQ-012 SHALL have ports load_pc (output, 1) and new_pc (output, 32), a one-cycle PC load strobe with its value.
REQ-013 SHALL have ports cur_proc (output, log2 NPROC) and idle (output, 1, high when no slot is valid).

Function
REQ-014 SHALL implement the states IDLE, RUN, DRAIN, SAVE, SELECT and LOAD.
REQ-015 SHALL hold, per slot, a valid bit and a 32-bit saved PC.
REQ-016 SHALL, in IDLE, have idle=1, and on proc_create go to LOAD, setting new_pc=create_pc and cur_proc=create_id.
REQ-017 SHALL, in RUN, increment a QW-bit counter on each tick; the counter saturates and never wraps.
REQ-018 SHALL treat a tick that makes the count equal to quantum, with enable=1 and quantum!=0, as expiry.
REQ-019 SHALL, on expiry, restart the count with no handshake when no other slot is valid; otherwise it SHALL go to DRAIN.
REQ-020 SHALL treat quantum=0 or enable=0 as never expiring.
REQ-021 SHALL, on proc_exit in RUN, clear the current valid bit and go to DRAIN; SAVE is skipped on this path.
REQ-022 SHALL hold switch_req=1 from entry to DRAIN until the load_pc cycle inclusive, and ignore tick while in DRAIN.
REQ-023 SHALL leave DRAIN on the first cycle in which switch_ack=1, going to SAVE (or to SELECT on the exit path).
REQ-024 SHALL, in SAVE, write cur_pc into the current slot's saved PC; this takes 1 cycle.
REQ-025 SHALL, in SELECT, pick the first valid slot searching cur_proc+1 upward modulo NPROC; this takes 1 cycle.
REQ-026 SHALL go to IDLE when no slot is valid during SELECT.
REQ-027 SHALL, in LOAD, pulse load_pc for exactly 1 cycle with new_pc=saved PC, update cur_proc, clear the counter and go to RUN.
REQ-028 SHALL give an expiry switch a latency of 3 cycles after switch_ack sampled high until load_pc.
REQ-029 SHALL accept proc_create in any state; when it coincides with SELECT or expiry, the new slot SHALL be visible to that SELECT.
REQ-030 SHALL ignore proc_create targeting the running slot while in RUN.
REQ-031 SHALL, when proc_exit and expiry coincide, give proc_exit priority.

Reset
REQ-032 SHALL, on reset low, immediately clear all valid bits and saved PCs and force the state to IDLE, with counter=0, cur_proc=0, switch_req=0, load_pc=0, new_pc=0 and idle=1, including mid-handshake.
REQ-033 SHALL synchronously release reset on the first clock edge after reset goes high.

Configuration
REQ-034 SHALL, when QSCHED_OS_RETURN_EN is defined, reserve slot 0 for the OS: every preemption and every exit from a user slot selects slot 0, and SELECT from slot 0 performs the round-robin over slots 1..NPROC-1.
REQ-035 SHALL, when QSCHED_OS_RETURN_EN is undefined, treat all slots equally under plain round-robin.

Structure
REQ-036 SHALL place the state enumeration, NPROC/QW defaults and the slot-index width function in shared package qsched_pkg.
REQ-037 SHALL implement the round-robin search in one sub-module, rr_pick (valid mask plus start index in; grant index and any_valid out; purely combinational).

Verification
REQ-038 SHALL verify: create slot 0 at PC 0x10 from IDLE -> load_pc pulse with new_pc=0x10, cur_proc=0, idle=0.
REQ-039 SHALL verify: slots 0 and 1 valid, quantum=5, 5 ticks, ack 2 cycles later -> slot 0 saves cur_pc, load_pc 3 cycles after ack with slot 1 PC.
REQ-040 SHALL verify: only slot 2 valid, quantum=3, 9 ticks -> switch_req never asserted, counter restarts each time.
REQ-041 SHALL verify: proc_exit on the same cycle as expiry with slot 3 as the sole other valid slot -> no SAVE, slot 3 loaded; a later exit -> idle=1.
REQ-042 SHALL verify: reset low while in DRAIN with switch_req=1 -> switch_req=0, state IDLE, all valid bits clear within the same cycle.
REQ-043 SHALL verify, with QSCHED_OS_RETURN_EN: slots 0, 1 and 2 valid, expiry in slot 1 -> slot 0 loaded; the next expiry -> slot 2 loaded.
